// File: rtl/button_press_decoder_if.sv
// -----------------------------------------------------------------------------
// button_press_decoder_if
//
// Bundles the raw push-button pin and the conditioned event outputs of
// button_press_decoder so the decoder and its consumers share one connection.
//
// Signals:
//   boton        raw, asynchronous button pin (1 = pressed)
//   btn_level    debounced button level
//   short_pulse  one-cycle pulse, short press completed
//   long_pulse   one-cycle pulse, long-press threshold reached
//   held         high from long_pulse until the debounced release
//   double_pulse one-cycle pulse, double press detected (0 when not built)
//
// Modports:
//   master  drives the pin, observes the events (board / consumer side)
//   slave   samples the pin, produces the events (decoder side)
// -----------------------------------------------------------------------------
interface button_press_decoder_if;
    logic boton;
    logic btn_level;
    logic short_pulse;
    logic long_pulse;
    logic held;
    logic double_pulse;

    modport master (
        output boton,
        input  btn_level,
        input  short_pulse,
        input  long_pulse,
        input  held,
        input  double_pulse
    );

    modport slave (
        input  boton,
        output btn_level,
        output short_pulse,
        output long_pulse,
        output held,
        output double_pulse
    );
endinterface

// File: rtl/button_press_decoder.sv
// -----------------------------------------------------------------------------
// button_press_decoder
//
// Conditions the raw Tamagotchi push-button for the pet FSM and display
// driver: two-flop synchroniser, debouncer, and a press classifier that emits
// single-cycle short/long (and optionally double) press events.
//
// Optional feature: define BUTTON_DOUBLE_PRESS_EN to build the double-press
// detector. Without it, double_pulse is tied 0 and short presses are
// reported on release; with it, short presses are reported only once the
// gap window after the release has expired without a second press.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 1)
//   LONG_CYCLES      high cycles that make a press long (>= 2)
//   GAP_CYCLES       release-to-second-press window for a double press (>= 1)
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   btn  button_press_decoder_if.slave: boton in; btn_level, short_pulse,
//        long_pulse, held, double_pulse out (all registered)
// -----------------------------------------------------------------------------
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int GAP_CYCLES      = 15000000
) (
    input  logic                         clk,
    input  logic                         rst,
    button_press_decoder_if.slave        btn
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PR_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(LONG_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || GAP_CYCLES < 1) begin : g_bad_params
            $error("button_press_decoder: parameter outside its legal range");
        end
    endgenerate

`ifdef BUTTON_DOUBLE_PRESS_EN
    localparam int GP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        DOUBLE_HELD
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;
`endif

    // ---- stage p0/p1: two-flop synchroniser on the raw pin ----
    logic sync_p0;
    logic sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync_p0 <= btn.boton;
            sync    <= sync_p0;
        end
    end

    // ---- debounce: level flips only after DEBOUNCE_CYCLES disagreeing cycles ----
    logic [DB_W-1:0] db_cnt;
    logic            btn_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt      <= '0;
            btn_level_q <= 1'b0;
        end else if (sync == btn_level_q) begin
            // Any return to the accepted level restarts the qualification.
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_level_q <= ~btn_level_q;
            db_cnt      <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // ---- edge detect on the debounced level ----
    logic btn_prev;
    logic rise;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_level_q;
        end
    end

    assign rise = btn_level_q & ~btn_prev;
    assign fall = ~btn_level_q & btn_prev;

    // ---- classifier FSM ----
    state_t          state;
    state_t          state_next;
    logic [PR_W-1:0] press_cnt;
    logic [PR_W-1:0] press_cnt_next;
    logic            short_next;
    logic            long_next;
    logic            held_next;
    logic            double_next;
`ifdef BUTTON_DOUBLE_PRESS_EN
    logic [GP_W-1:0] gap_cnt;
    logic [GP_W-1:0] gap_cnt_next;
`endif

    always_comb begin
        state_next     = state;
        press_cnt_next = press_cnt;
        short_next     = 1'b0;
        long_next      = 1'b0;
        held_next      = 1'b0;
        double_next    = 1'b0;
`ifdef BUTTON_DOUBLE_PRESS_EN
        gap_cnt_next   = gap_cnt;
`endif

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next     = PRESSED;
                    press_cnt_next = PR_W'(1);
                end
            end

            // PRESSED/LONG_HELD/DOUBLE_HELD are only entered on a rise and
            // left on a fall, so "not fall" here means the level is still high.
            PRESSED: begin
                if (fall) begin
`ifdef BUTTON_DOUBLE_PRESS_EN
                    state_next   = WAIT_SECOND;
                    gap_cnt_next = GP_W'(1);
`else
                    state_next   = IDLE;
                    short_next   = 1'b1;
`endif
                end else if (press_cnt == PR_LAST) begin
                    // press_cnt stays parked at LONG_CYCLES-1 (saturated).
                    state_next = LONG_HELD;
                    long_next  = 1'b1;
                end else begin
                    press_cnt_next = press_cnt + PR_W'(1);
                end
            end

            LONG_HELD: begin
                if (fall) begin
                    state_next = IDLE;
                end else begin
                    held_next = 1'b1;
                end
            end

`ifdef BUTTON_DOUBLE_PRESS_EN
            WAIT_SECOND: begin
                // Rise is tested first so a second press landing in the
                // expiry cycle is still reported as a double.
                if (rise) begin
                    state_next  = DOUBLE_HELD;
                    double_next = 1'b1;
                end else if (gap_cnt == GP_LAST) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt + GP_W'(1);
                end
            end

            DOUBLE_HELD: begin
                if (fall) begin
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            press_cnt <= '0;
        end else begin
            state     <= state_next;
            press_cnt <= press_cnt_next;
        end
    end

`ifdef BUTTON_DOUBLE_PRESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt_next;
        end
    end
`endif

    // ---- registered event outputs ----
    logic short_q;
    logic long_q;
    logic held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            short_q <= short_next;
            long_q  <= long_next;
            held_q  <= held_next;
        end
    end

`ifdef BUTTON_DOUBLE_PRESS_EN
    logic double_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            double_q <= 1'b0;
        end else begin
            double_q <= double_next;
        end
    end

    assign btn.double_pulse = double_q;
`else
    assign btn.double_pulse = 1'b0;
`endif

    assign btn.btn_level   = btn_level_q;
    assign btn.short_pulse = short_q;
    assign btn.long_pulse  = long_q;
    assign btn.held        = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_press_decoder
//
// Directed and random stimulus for button_press_decoder with
// DEBOUNCE_CYCLES=4, LONG_CYCLES=20, GAP_CYCLES=10. Expected outputs come
// from a reference model that tracks the debounced level and the length of
// the current high run, and derives events from press durations.
// -----------------------------------------------------------------------------
module tb_button_press_decoder;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int GP = 10;
`ifdef BUTTON_DOUBLE_PRESS_EN
    localparam int SHORT_LAT = GP + 1;
`else
    localparam int SHORT_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    button_press_decoder_if bif ();

    button_press_decoder #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .GAP_CYCLES      (GP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit m_s1, m_s2, m_lvl;
    int m_diff, m_run;
    int pend;
    bit ign;
    bit e_short, e_long, e_held, e_double;
    bit x_short, x_long, x_held, x_double;

    // observation bookkeeping
    int n_short, n_long, n_double, n_held, n_rise;
    int t_rise, t_fall, t_long, t_short, t_held_fall;
    bit lvl_seen, held_seen;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_diff = 0; m_run = 0;
        pend = -1; ign = 0;
        e_short = 0; e_long = 0; e_held = 0; e_double = 0;
        x_short = 0; x_long = 0; x_held = 0; x_double = 0;
    endtask

    // One clock edge of the model; b is the pin value sampled by that edge.
    task automatic model_tick(input bit b);
        bit prev_lvl;
        int prev_run;
        bit rise, fall;
        // outputs now visible were decided by last cycle's events
        x_short  = e_short;
        x_long   = e_long;
        x_held   = e_held;
        x_double = e_double;
        prev_lvl = m_lvl;
        prev_run = m_run;
        // level changes once the synchronised pin disagreed DB cycles in a row
        if (m_s2 != m_lvl) begin
            if (m_diff + 1 == DB) begin
                m_lvl  = !m_lvl;
                m_diff = 0;
            end else begin
                m_diff++;
            end
        end else begin
            m_diff = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_run = m_lvl ? m_run + 1 : 0;
        rise = m_lvl && !prev_lvl;
        fall = !m_lvl && prev_lvl;
        // events of this cycle show on the outputs next cycle
        e_long   = m_lvl && (m_run == LG) && !ign;
        e_held   = m_lvl && (m_run > LG) && !ign;
        e_short  = 0;
        e_double = 0;
`ifdef BUTTON_DOUBLE_PRESS_EN
        if (pend >= 0 && rise) begin
            e_double = 1;
            ign      = 1;
            pend     = -1;
        end else if (pend >= 0 && (cyc - pend) == GP) begin
            e_short = 1;
            pend    = -1;
        end
        if (fall) begin
            if (ign) ign = 0;
            else if (prev_run < LG) pend = cyc;
        end
`else
        e_short = fall && (prev_run < LG);
`endif
    endtask

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_double = 0; n_held = 0; n_rise = 0;
        t_rise = -1; t_fall = -1; t_long = -1; t_short = -1; t_held_fall = -1;
    endtask

    task automatic step(input logic b);
        bif.boton = b;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) model_reset();
        else model_tick(b);
        check("btn_level", bif.btn_level, m_lvl);
        check("short_pulse", bif.short_pulse, x_short);
        check("long_pulse", bif.long_pulse, x_long);
        check("held", bif.held, x_held);
        check("double_pulse", bif.double_pulse, x_double);
        check("one_event", ((32'(bif.short_pulse) + 32'(bif.long_pulse) + 32'(bif.double_pulse)) <= 1), 1'b1);
        if (bif.btn_level && !lvl_seen) begin n_rise++; t_rise = cyc; end
        if (!bif.btn_level && lvl_seen) t_fall = cyc;
        lvl_seen = bif.btn_level;
        if (!bif.held && held_seen) t_held_fall = cyc;
        held_seen = bif.held;
        if (bif.short_pulse)  begin n_short++; t_short = cyc; end
        if (bif.long_pulse)   begin n_long++;  t_long  = cyc; end
        if (bif.double_pulse) n_double++;
        if (bif.held)         n_held++;
    endtask

    task automatic press(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    initial begin
        int c0;
        int k;
        bit b;
        model_reset();
        clear_counts();
        bif.boton = 1'b0;

        // reset state
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // bounce: toggle every 2 cycles for 20 cycles
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        end
        for (int i = 0; i < 10; i++) step(1'b0);
        check_int("bounce_level_rises", n_rise, 0);
        check_int("bounce_events", n_short + n_long + n_double, 0);

        // short press
        clear_counts();
        c0 = cyc;
        press(12, 30);
        check_int("short_level_delay", t_rise - c0, 2 + DB);
        check_int("short_count", n_short, 1);
        check_int("short_latency", t_short - t_fall, SHORT_LAT);
        check_int("short_no_long", n_long, 0);
        check_int("short_no_held", n_held, 0);

        // long press
        clear_counts();
        press(40, 30);
        check_int("long_count", n_long, 1);
        check_int("long_no_short", n_short, 0);
        check_int("long_after_rise", t_long - t_rise, LG);
        check_int("long_held_cycles", n_held, 40 - LG);
        check_int("long_held_release", t_held_fall - t_fall, 1);

        // threshold: exactly LG high cycles is long, LG-1 is short
        clear_counts();
        press(LG, 30);
        check_int("thr_long_count", n_long, 1);
        check_int("thr_long_no_short", n_short, 0);
        clear_counts();
        press(LG - 1, 30);
        check_int("thr_short_count", n_short, 1);
        check_int("thr_short_no_long", n_long, 0);

        // reset three cycles into PRESSED while still held
        clear_counts();
        bif.boton = 1'b1;
        k = 0;
        while (!bif.btn_level && k < 20) begin
            step(1'b1);
            k++;
        end
        check("rst_level_up", bif.btn_level, 1'b1);
        step(1'b1); step(1'b1); step(1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_level", bif.btn_level, 1'b0);
        check("rst_async_short", bif.short_pulse, 1'b0);
        check("rst_async_long", bif.long_pulse, 1'b0);
        check("rst_async_held", bif.held, 1'b0);
        check("rst_async_double", bif.double_pulse, 1'b0);
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) step(1'b1);
        check_int("rst_no_early_level", n_rise, 0);
        check_int("rst_no_early_event", n_short + n_long + n_double, 0);
        for (int i = 0; i < 7; i++) step(1'b1);
        for (int i = 0; i < 30; i++) step(1'b0);
        check_int("rst_redebounce_rise", n_rise, 1);
        check_int("rst_redebounce_short", n_short, 1);

`ifdef BUTTON_DOUBLE_PRESS_EN
        // double press: 5-cycle gap gives one double, 12-cycle gap two shorts
        clear_counts();
        press(8, 5);
        press(8, 30);
        check_int("dbl_count", n_double, 1);
        check_int("dbl_no_short", n_short, 0);
        clear_counts();
        press(8, 12);
        press(8, 30);
        check_int("dbl_gap_shorts", n_short, 2);
        check_int("dbl_gap_no_double", n_double, 0);
`endif

        // random pin activity, including bounce and long holds
        for (int i = 0; i < 80; i++) begin
            b = 1'($urandom_range(0, 1));
            k = (i % 4 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 45));
            for (int j = 0; j < k; j++) step(b);
        end
        for (int i = 0; i < 40; i++) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
